router_stat_sampler: RTL and testbench

Synthesizable per-output traffic statistics unit that attaches to bsg_mesh_router. It is a parametrised successor to the simulation-only router profiler.
- Counts idle / utilized / stalled / arbitrated cycles per output direction in saturating counters.
- Takes atomic snapshots on an external request or on a programmable periodic window.
- Streams each snapshot out one direction per record over a valid/ready interface, so stats can be drained by a tile or host logger instead of $fwrite.

---
 rtl/router_stat_sampler_if.sv | 38 +++
 rtl/router_stat_sampler.sv | 150 +++++++++++++++
 tb/tb_router_stat_sampler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_stat_sampler_if.sv
// Stat sampler bundle: router request/grant matrices and snapshot controls in,
// per-direction statistic records out over a valid/ready stream.
interface router_stat_sampler_if #(
  parameter int dirs_p         = 5,
  parameter int ctr_width_p    = 32,
  parameter int period_width_p = 16,
  parameter int tag_width_p    = 32
);
  localparam int dir_width_lp = (dirs_p > 1) ? $clog2(dirs_p) : 1;

  logic [dirs_p*dirs_p-1:0]  req;
  logic [dirs_p*dirs_p-1:0]  yumi;
  logic                      snap_v;
  logic [tag_width_p-1:0]    snap_tag;
  logic [period_width_p-1:0] period;
  logic                      stat_v;
  logic                      stat_ready;
  logic [tag_width_p-1:0]    stat_tag;
  logic [dir_width_lp-1:0]   stat_dir;
  logic [ctr_width_p-1:0]    stat_idle;
  logic [ctr_width_p-1:0]    stat_util;
  logic [ctr_width_p-1:0]    stat_stall;
  logic [ctr_width_p-1:0]    stat_arb;
  logic                      busy;
  logic [ctr_width_p-1:0]    snap_drop;

  modport master (
    input  req, yumi, snap_v, snap_tag, period, stat_ready,
    output stat_v, stat_tag, stat_dir, stat_idle, stat_util, stat_stall, stat_arb,
           busy, snap_drop
  );

  modport slave (
    output req, yumi, snap_v, snap_tag, period, stat_ready,
    input  stat_v, stat_tag, stat_dir, stat_idle, stat_util, stat_stall, stat_arb,
           busy, snap_drop
  );
endinterface

// File: rtl/router_stat_sampler.sv
// Per-output router traffic statistics: saturating live counters, atomic snapshots
// (external or periodic) and a one-direction-per-record drain over valid/ready.
module router_stat_sampler #(
  parameter int dims_p          = 2,
  parameter int ctr_width_p     = 32,
  parameter int period_width_p  = 16,
  parameter int clear_on_snap_p = 1,
  parameter int tag_width_p     = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  router_stat_sampler_if.master bus
);
  localparam int dirs_lp      = 1 + 2*dims_p;
  localparam int dir_width_lp = (dirs_lp > 1) ? $clog2(dirs_lp) : 1;
  localparam int n_stats_lp   = 4;

  typedef enum logic {s_idle, s_send} state_e;

  logic [dirs_lp-1:0]                                   req_row [dirs_lp];
  logic [dirs_lp-1:0]                                   yumi_row [dirs_lp];
  logic [n_stats_lp-1:0][dirs_lp-1:0]                   ev;
  logic [n_stats_lp-1:0][dirs_lp-1:0][ctr_width_p-1:0] live;
  logic [n_stats_lp-1:0][dirs_lp-1:0][ctr_width_p-1:0] shadow;
  logic [period_width_p-1:0] period_cnt;
  logic [tag_width_p-1:0]    window_idx;
  logic [tag_width_p-1:0]    trig_tag;
  logic [tag_width_p-1:0]    tag_q;
  logic [dir_width_lp-1:0]   dir;
  logic [ctr_width_p-1:0]    drop_cnt;
  logic                      periodic, trig, capture, drop;
  logic                      stat_v_q, busy_q;
  state_e                    state;

  function automatic logic multi_hot(input logic [dirs_lp-1:0] x);
    return (x & (x - dirs_lp'(1))) != '0;
  endfunction

  function automatic logic [ctr_width_p-1:0] sat_inc(input logic [ctr_width_p-1:0] v,
                                                     input logic e);
    return (e && (v != '1)) ? v + ctr_width_p'(1) : v;
  endfunction

  // Stat index order: 0 idle, 1 util, 2 stall, 3 arb.
  always_comb begin
    req_row  = '{default: '0};
    yumi_row = '{default: '0};
    ev       = '0;
    for (int o = 0; o < dirs_lp; o++) begin
      req_row[o]  = bus.req[o*dirs_lp +: dirs_lp];
      yumi_row[o] = bus.yumi[o*dirs_lp +: dirs_lp];
      ev[0][o] = (req_row[o] == '0);
      ev[1][o] = ((req_row[o] & yumi_row[o]) != '0);
      ev[2][o] = (req_row[o] != '0) && (yumi_row[o] == '0);
      ev[3][o] = multi_hot(req_row[o]) && (yumi_row[o] != '0);
    end
  end

  assign periodic = (bus.period != '0) && (period_cnt == bus.period - period_width_p'(1));
  assign trig     = bus.snap_v | periodic;
  assign capture  = trig && (state == s_idle);
  assign drop     = trig && (state != s_idle);
  assign trig_tag = bus.snap_v ? bus.snap_tag : {1'b0, window_idx[tag_width_p-2:0]};

  // A period shrunk below the running count lets the counter roll over before matching.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      period_cnt <= '0;
      window_idx <= '0;
    end else begin
      if ((bus.period == '0) || periodic)
        period_cnt <= '0;
      else
        period_cnt <= period_cnt + period_width_p'(1);
      if (periodic)
        window_idx <= window_idx + tag_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      live     <= '0;
      shadow   <= '0;
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < n_stats_lp; k++) begin
        for (int o = 0; o < dirs_lp; o++) begin
          if (capture && (clear_on_snap_p != 0))
            live[k][o] <= ctr_width_p'(ev[k][o]);
          else
            live[k][o] <= sat_inc(live[k][o], ev[k][o]);
        end
      end
      if (capture)
        shadow <= live;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + ctr_width_p'(1);
    end
  end

  // Shadow is frozen for the whole drain, so the muxed record fields stay stable under backpressure.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= s_idle;
      dir      <= '0;
      tag_q    <= '0;
      stat_v_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        s_idle: begin
          if (trig) begin
            state    <= s_send;
            dir      <= '0;
            tag_q    <= trig_tag;
            stat_v_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        s_send: begin
          if (bus.stat_ready) begin
            if (dir == dir_width_lp'(dirs_lp-1)) begin
              state    <= s_idle;
              dir      <= '0;
              stat_v_q <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              dir <= dir + dir_width_lp'(1);
            end
          end
        end
        default: begin
          state    <= s_idle;
          stat_v_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stat_v     = stat_v_q;
  assign bus.busy       = busy_q;
  assign bus.stat_tag   = tag_q;
  assign bus.stat_dir   = dir;
  assign bus.stat_idle  = shadow[0][dir];
  assign bus.stat_util  = shadow[1][dir];
  assign bus.stat_stall = shadow[2][dir];
  assign bus.stat_arb   = shadow[3][dir];
  assign bus.snap_drop  = drop_cnt;
endmodule

// File: tb/tb_router_stat_sampler.sv
// Scoreboard bench: stimulus pushes hand-computed records, per-instance monitors
// pop and compare on every accepted record. dut_a clears on snapshot, dut_b is cumulative 4-bit.
module tb_router_stat_sampler;
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] dir;
    logic [31:0] idle;
    logic [31:0] util;
    logic [31:0] stall;
    logic [31:0] arb;
  } rec_t;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  rec_t exp_a[$];
  rec_t exp_b[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  router_stat_sampler_if #(.dirs_p(5), .ctr_width_p(8), .period_width_p(16), .tag_width_p(32)) if_a ();
  router_stat_sampler_if #(.dirs_p(5), .ctr_width_p(4), .period_width_p(16), .tag_width_p(32)) if_b ();

  router_stat_sampler #(.dims_p(2), .ctr_width_p(8), .period_width_p(16),
                        .clear_on_snap_p(1), .tag_width_p(32))
    dut_a (.clk_i(clk), .reset_i(reset_a), .bus(if_a.master));

  router_stat_sampler #(.dims_p(2), .ctr_width_p(4), .period_width_p(16),
                        .clear_on_snap_p(0), .tag_width_p(32))
    dut_b (.clk_i(clk), .reset_i(reset_b), .bus(if_b.master));

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic push_rec(input bit to_b, input logic [31:0] tag, input int dir,
                          input int idle, input int util, input int stall, input int arb);
    rec_t r;
    r.tag = tag; r.dir = dir; r.idle = idle; r.util = util; r.stall = stall; r.arb = arb;
    if (to_b) exp_b.push_back(r);
    else      exp_a.push_back(r);
  endtask

  task automatic push_uniform(input bit to_b, input logic [31:0] tag, input int idle);
    for (int d = 0; d < 5; d++) push_rec(to_b, tag, d, idle, 0, 0, 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [24:0] req, input logic [24:0] yumi,
                               input logic snap, input logic [31:0] tag, input int n);
    if_a.req = req; if_a.yumi = yumi; if_a.snap_v = snap; if_a.snap_tag = tag;
    tick(n);
  endtask

  task automatic applyStimulusB(input logic [24:0] req, input logic snap,
                                input logic [31:0] tag, input int n);
    if_b.req = req; if_b.yumi = '0; if_b.snap_v = snap; if_b.snap_tag = tag;
    tick(n);
  endtask

  task automatic check_record(input bit is_b, input rec_t got);
    rec_t want;
    string name;
    name = is_b ? "rec_b" : "rec_a";
    n_checks++;
    if ((is_b && exp_b.size() == 0) || (!is_b && exp_a.size() == 0)) begin
      n_fails++;
      $display("[TB] FAIL %s unexpected: got tag=%0h dir=%0d idle=%0d, required no record",
               name, got.tag, got.dir, got.idle);
    end else begin
      want = is_b ? exp_b.pop_front() : exp_a.pop_front();
      if (got !== want) begin
        n_fails++;
        $display("[TB] FAIL %s: got tag=%0h dir=%0d idle=%0d util=%0d stall=%0d arb=%0d, required tag=%0h dir=%0d idle=%0d util=%0d stall=%0d arb=%0d",
                 name, got.tag, got.dir, got.idle, got.util, got.stall, got.arb,
                 want.tag, want.dir, want.idle, want.util, want.stall, want.arb);
      end
    end
  endtask

  always @(negedge clk) begin
    rec_t got;
    if (if_a.stat_v === 1'b1 && if_a.stat_ready === 1'b1) begin
      got.tag = if_a.stat_tag; got.dir = 32'(if_a.stat_dir);
      got.idle = 32'(if_a.stat_idle); got.util = 32'(if_a.stat_util);
      got.stall = 32'(if_a.stat_stall); got.arb = 32'(if_a.stat_arb);
      check_record(1'b0, got);
    end
  end

  always @(negedge clk) begin
    rec_t got;
    if (if_b.stat_v === 1'b1 && if_b.stat_ready === 1'b1) begin
      got.tag = if_b.stat_tag; got.dir = 32'(if_b.stat_dir);
      got.idle = 32'(if_b.stat_idle); got.util = 32'(if_b.stat_util);
      got.stall = 32'(if_b.stat_stall); got.arb = 32'(if_b.stat_arb);
      check_record(1'b1, got);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    if_a.req = '0; if_a.yumi = '0; if_a.snap_v = 1'b0; if_a.snap_tag = '0;
    if_a.period = '0; if_a.stat_ready = 1'b1;
    if_b.req = '0; if_b.yumi = '0; if_b.snap_v = 1'b0; if_b.snap_tag = '0;
    if_b.period = '0; if_b.stat_ready = 1'b1;
    tick(3);
    checkOutput("reset_stat_v", 32'(if_a.stat_v), 0);
    checkOutput("reset_busy", 32'(if_a.busy), 0);
    checkOutput("reset_dir", 32'(if_a.stat_dir), 0);
    checkOutput("reset_snap_drop", 32'(if_a.snap_drop), 0);
    checkOutput("reset_b_stat_v", 32'(if_b.stat_v), 0);
    reset_a = 1'b0;

    $display("[TB] idle traffic then external snapshot");
    applyStimulus('0, '0, 1'b0, 0, 10);
    push_uniform(1'b0, 32'hA5, 10);
    applyStimulus('0, '0, 1'b1, 32'hA5, 1);
    checkOutput("first_record_latency", 32'(if_a.stat_v), 1);
    checkOutput("busy_in_send", 32'(if_a.busy), 1);
    applyStimulus('0, '0, 1'b0, 0, 5);
    checkOutput("idle_after_drain", 32'(if_a.busy), 0);

    $display("[TB] output E contended by W and N");
    for (int t = 1; t <= 6; t++)
      applyStimulus(25'h002800, (t % 2 == 0) ? 25'h000800 : 25'h0, 1'b0, 0, 1);
    push_rec(1'b0, 32'h1234, 0, 12, 0, 0, 0);
    push_rec(1'b0, 32'h1234, 1, 12, 0, 0, 0);
    push_rec(1'b0, 32'h1234, 2, 6, 3, 3, 3);
    push_rec(1'b0, 32'h1234, 3, 12, 0, 0, 0);
    push_rec(1'b0, 32'h1234, 4, 12, 0, 0, 0);
    applyStimulus('0, '0, 1'b1, 32'h1234, 1);
    applyStimulus('0, '0, 1'b0, 0, 5);

    $display("[TB] backpressure with dropped snapshots");
    if_a.stat_ready = 1'b0;
    applyStimulus('0, '0, 1'b0, 0, 4);
    push_uniform(1'b0, 32'h77, 10);
    applyStimulus('0, '0, 1'b1, 32'h77, 1);
    applyStimulus('0, '0, 1'b1, 32'hEE, 1);
    applyStimulus('0, '0, 1'b0, 0, 1);
    applyStimulus('0, '0, 1'b1, 32'hEE, 1);
    applyStimulus('0, '0, 1'b0, 0, 2);
    checkOutput("snap_drop_count", 32'(if_a.snap_drop), 2);
    checkOutput("held_stat_v", 32'(if_a.stat_v), 1);
    checkOutput("held_dir", 32'(if_a.stat_dir), 0);
    checkOutput("held_tag", if_a.stat_tag, 32'h77);
    checkOutput("held_idle", 32'(if_a.stat_idle), 10);
    if_a.stat_ready = 1'b1;
    applyStimulus('0, '0, 1'b0, 0, 5);
    checkOutput("idle_after_backpressure", 32'(if_a.busy), 0);

    $display("[TB] reset during drain");
    push_rec(1'b0, 32'h3C, 0, 11, 0, 0, 0);
    applyStimulus('0, '0, 1'b1, 32'h3C, 1);
    applyStimulus('0, '0, 1'b0, 0, 1);
    checkOutput("second_record_dir", 32'(if_a.stat_dir), 1);
    reset_a = 1'b1;
    if_a.stat_ready = 1'b0;
    tick(1);
    checkOutput("rst_mid_stat_v", 32'(if_a.stat_v), 0);
    checkOutput("rst_mid_busy", 32'(if_a.busy), 0);
    checkOutput("rst_mid_snap_drop", 32'(if_a.snap_drop), 0);
    checkOutput("rst_mid_dir", 32'(if_a.stat_dir), 0);
    reset_a = 1'b0;
    if_a.stat_ready = 1'b1;
    applyStimulus(25'h000010, '0, 1'b0, 0, 2);
    applyStimulus('0, '0, 1'b0, 0, 3);
    push_rec(1'b0, 32'h5A, 0, 3, 0, 2, 0);
    for (int d = 1; d < 5; d++) push_rec(1'b0, 32'h5A, d, 5, 0, 0, 0);
    applyStimulus('0, '0, 1'b1, 32'h5A, 1);
    applyStimulus('0, '0, 1'b0, 0, 5);

    $display("[TB] periodic snapshots, clear on snapshot");
    reset_a = 1'b1;
    if_a.period = 16'd100;
    tick(2);
    reset_a = 1'b0;
    push_uniform(1'b0, 32'd0, 99);
    push_uniform(1'b0, 32'd1, 100);
    push_uniform(1'b0, 32'd2, 100);
    tick(310);
    if_a.period = '0;
    tick(5);

    $display("[TB] saturation on 4-bit cumulative instance");
    checkOutput("reset_b_busy", 32'(if_b.busy), 0);
    reset_b = 1'b0;
    applyStimulusB(25'h000002, 1'b0, 0, 20);
    push_rec(1'b1, 32'hB1, 0, 0, 0, 15, 0);
    for (int d = 1; d < 5; d++) push_rec(1'b1, 32'hB1, d, 15, 0, 0, 0);
    applyStimulusB('0, 1'b1, 32'hB1, 1);
    applyStimulusB('0, 1'b0, 0, 5);

    $display("[TB] periodic snapshots, cumulative");
    reset_b = 1'b1;
    if_b.period = 16'd6;
    tick(1);
    reset_b = 1'b0;
    push_uniform(1'b1, 32'd0, 5);
    push_uniform(1'b1, 32'd1, 11);
    push_uniform(1'b1, 32'd2, 15);
    tick(23);
    if_b.period = '0;
    tick(3);

    checkOutput("queue_a_drained", exp_a.size(), 0);
    checkOutput("queue_b_drained", exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
